// File: rtl/hbridge_startup_sequencer.sv
`timescale 1ns/1ps
// Registered H-bridge gate stage: bootstrap pre-charge, forced sigma=+1, then dead-timed pass-through
// with a latched shoot-through fault. Define HB_WATCHDOG_EN to add a stalled-input watchdog in RUN.
module hbridge_startup_sequencer #(
    parameter int CLK_DIV     = 100,
    parameter int T_PRECHARGE = 11,
    parameter int T_FORCE     = 6,
    parameter int T_WDT       = 50
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic       i_fault_clear,
    input  logic [3:0] i_Q,
    output logic [3:0] o_Q,
    output logic [2:0] o_state,
    output logic       o_on,
    output logic       o_vg,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    localparam int MAX_T = (T_PRECHARGE > T_FORCE)
                         ? ((T_PRECHARGE > T_WDT) ? T_PRECHARGE : T_WDT)
                         : ((T_FORCE > T_WDT) ? T_FORCE : T_WDT);
    localparam int CNT_W = $clog2(MAX_T * CLK_DIV);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(T_PRECHARGE * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(T_FORCE * CLK_DIV - 1);
`ifdef HB_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(T_WDT * CLK_DIV - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_FORCE     = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gate_q, gate_d;
    logic             en_q;
    logic             on_q, on_d;
    logic             vg_q, vg_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             shoot;
`ifdef HB_WATCHDOG_EN
    logic [3:0]       iq_prev_q;
`endif

    assign shoot = (i_Q[0] & i_Q[2]) | (i_Q[1] & i_Q[3]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        code_d  = code_q;

        // Shoot-through outranks enable loss, which outranks any phase timeout.
        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (!i_enable)              state_d = ST_IDLE;
                else if (cnt_q == PRE_LAST) state_d = ST_FORCE;
            end
            ST_FORCE: begin
                if (!i_enable)                state_d = ST_IDLE;
                else if (cnt_q == FORCE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (shoot) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b01;
                end else if (!i_enable) begin
                    state_d = ST_IDLE;
                end
`ifdef HB_WATCHDOG_EN
                else if (i_Q != iq_prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == WDT_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b10;
                end
`endif
            end
            ST_FAULT: begin
                if (i_fault_clear && !i_enable) begin
                    state_d = ST_IDLE;
                    code_d  = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = 2'b00;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs follow the next state so pins and status change on the same edge.
        case (state_d)
            ST_PRECHARGE: gate_d = 4'b1100;
            ST_FORCE:     gate_d = 4'b1001;
            ST_RUN:       gate_d = shoot ? 4'b0000 : i_Q;
            default:      gate_d = 4'b0000;
        endcase

        on_d    = (state_d == ST_FORCE) || (state_d == ST_RUN);
        vg_d    = (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gate_q    <= 4'b0000;
            en_q      <= 1'b0;
            on_q      <= 1'b0;
            vg_q      <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= 2'b00;
`ifdef HB_WATCHDOG_EN
            iq_prev_q <= 4'b0000;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_q    <= gate_d;
            en_q      <= i_enable;
            on_q      <= on_d;
            vg_q      <= vg_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
`ifdef HB_WATCHDOG_EN
            iq_prev_q <= i_Q;
`endif
        end
    end

    // Independent last-line interlock: pins are forced off one cycle after enable drops.
    assign o_Q          = gate_q & {4{en_q}};
    assign o_state      = state_q;
    assign o_on         = on_q;
    assign o_vg         = vg_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;

endmodule

// File: tb/tb_hbridge_startup_sequencer.sv
`timescale 1ns/1ps
// Directed bench for hbridge_startup_sequencer: cycle model compared every cycle plus literal checkpoints.
module tb_hbridge_startup_sequencer;

    localparam int PRE_CYC   = 1100;
    localparam int FORCE_CYC = 600;
    localparam int WDT_CYC   = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] iq  = 4'b0000;
    logic [3:0] oq;
    logic [2:0] ost;
    logic       on_o, vg_o, flt;
    logic [1:0] code;

    int n_vec = 0;
    int n_bad = 0;

    hbridge_startup_sequencer dut (
        .i_clock      (clk),
        .i_RESET      (rst),
        .i_enable     (en),
        .i_fault_clear(clr),
        .i_Q          (iq),
        .o_Q          (oq),
        .o_state      (ost),
        .o_on         (on_o),
        .o_vg         (vg_o),
        .o_fault      (flt),
        .o_fault_code (code)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase start stamps and elapsed-edge arithmetic.
    int         m_mode = 0;
    int         m_cyc = 0;
    int         m_since = 0;
    logic [3:0] m_pins = 4'b0000;
    logic [1:0] m_code = 2'b00;
    logic [3:0] m_last_iq = 4'b0000;

    always @(posedge clk or posedge rst) begin : model
        int         nm;
        int         since;
        int         now;
        logic [3:0] pat;
        logic [1:0] nc;
        bit         shoot;
        if (rst) begin
            m_mode    <= 0;
            m_cyc     <= 0;
            m_since   <= 0;
            m_pins    <= 4'b0000;
            m_code    <= 2'b00;
            m_last_iq <= 4'b0000;
        end else begin
            now   = m_cyc + 1;
            nm    = m_mode;
            nc    = m_code;
            since = m_since;
            shoot = (iq[0] && iq[2]) || (iq[1] && iq[3]);
            case (m_mode)
                0: if (en) nm = 1;
                1: if (!en) nm = 0; else if (now - m_since == PRE_CYC) nm = 2;
                2: if (!en) nm = 0; else if (now - m_since == FORCE_CYC) nm = 3;
                3: begin
                    if (shoot) begin nm = 4; nc = 2'b01; end
                    else if (!en) nm = 0;
`ifdef HB_WATCHDOG_EN
                    else if (iq != m_last_iq) since = now;
                    else if (now - m_since == WDT_CYC) begin nm = 4; nc = 2'b10; end
`endif
                end
                default: if (clr && !en) begin nm = 0; nc = 2'b00; end
            endcase
            if (nm != m_mode) since = now;
            case (nm)
                1:       pat = 4'b1100;
                2:       pat = 4'b1001;
                3:       pat = shoot ? 4'b0000 : iq;
                default: pat = 4'b0000;
            endcase
            if (!en) pat = 4'b0000;
            m_mode    <= nm;
            m_cyc     <= now;
            m_since   <= since;
            m_pins    <= pat;
            m_code    <= nc;
            m_last_iq <= iq;
        end
    end

    always @(negedge clk) begin
        logic [2:0] ms;
        ms = m_mode[2:0];
        n_vec++;
        if (oq !== m_pins || ost !== ms || on_o !== (m_mode == 2 || m_mode == 3) ||
            vg_o !== (m_mode == 3) || flt !== (m_mode == 4) || code !== m_code) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got Q=%b st=%0d on=%b vg=%b flt=%b code=%b, want Q=%b st=%0d flt=%b code=%b",
                     $time, oq, ost, on_o, vg_o, flt, code, m_pins, ms, (m_mode == 4), m_code);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] q, input logic [2:0] st,
                              input logic fault, input logic [1:0] fc);
        n_vec++;
        if (oq !== q || ost !== st || flt !== fault || code !== fc || vg_o !== (st == 3'd3)) begin
            n_bad++;
            $display("FAIL %s: got Q=%b st=%0d fault=%b code=%b vg=%b, want Q=%b st=%0d fault=%b code=%b",
                     name, oq, ost, flt, code, vg_o, q, st, fault, fc);
        end else begin
            $display("ok   %s: Q=%b st=%0d fault=%b code=%b", name, oq, ost, flt, code);
        end
    endtask

    task automatic start_to_run(input logic [3:0] pat);
        iq = pat;
        en = 1'b1;
        cyc(1 + PRE_CYC + FORCE_CYC);
    endtask

    logic [3:0] legal_tbl [5] = '{4'b0110, 4'b0001, 4'b1000, 4'b0000, 4'b1001};

    initial begin
        #1 rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        expect_out("reset", 4'b0000, 3'd0, 1'b0, 2'b00);
        cyc(2);

        // Start-up timing
        iq = 4'b1001;
        en = 1'b1;
        cyc(1);
        expect_out("pre_first", 4'b1100, 3'd1, 1'b0, 2'b00);
        cyc(PRE_CYC - 1);
        expect_out("pre_last", 4'b1100, 3'd1, 1'b0, 2'b00);
        cyc(1);
        expect_out("force_first", 4'b1001, 3'd2, 1'b0, 2'b00);
        cyc(FORCE_CYC - 1);
        expect_out("force_last", 4'b1001, 3'd2, 1'b0, 2'b00);
        cyc(1);
        expect_out("run_entry", 4'b1001, 3'd3, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            iq = legal_tbl[i];
            cyc(1);
            expect_out($sformatf("run_pass_%0d", i), legal_tbl[i], 3'd3, 1'b0, 2'b00);
        end

        // Shoot-through
        iq = 4'b0101;
        cyc(1);
        expect_out("shoot", 4'b0000, 3'd4, 1'b1, 2'b01);
        iq = 4'b0000;
        cyc(3);
        expect_out("fault_hold", 4'b0000, 3'd4, 1'b1, 2'b01);

        // Fault clear
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        expect_out("clear_ignored", 4'b0000, 3'd4, 1'b1, 2'b01);
        en = 1'b0;
        cyc(2);
        expect_out("fault_no_clear", 4'b0000, 3'd4, 1'b1, 2'b01);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        expect_out("clear_done", 4'b0000, 3'd0, 1'b0, 2'b00);

        // Enable drop mid pre-charge, then a full pre-charge
        iq = 4'b1001;
        en = 1'b1;
        cyc(1);
        cyc(499);
        en = 1'b0;
        cyc(1);
        expect_out("drop_pre", 4'b0000, 3'd0, 1'b0, 2'b00);
        cyc(3);
        en = 1'b1;
        cyc(1);
        cyc(PRE_CYC - 1);
        expect_out("repre_last", 4'b1100, 3'd1, 1'b0, 2'b00);
        cyc(1);
        expect_out("reforce_first", 4'b1001, 3'd2, 1'b0, 2'b00);

        // Enable drop coinciding with FORCE timeout
        cyc(FORCE_CYC - 1);
        en = 1'b0;
        cyc(1);
        expect_out("drop_beats_timeout", 4'b0000, 3'd0, 1'b0, 2'b00);
        cyc(2);

        // Shoot-through coinciding with enable drop
        start_to_run(4'b1001);
        expect_out("run_again", 4'b1001, 3'd3, 1'b0, 2'b00);
        iq = 4'b1010;
        en = 1'b0;
        cyc(1);
        expect_out("shoot_beats_drop", 4'b0000, 3'd4, 1'b1, 2'b01);
        iq = 4'b0000;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        expect_out("clear2", 4'b0000, 3'd0, 1'b0, 2'b00);

        // Async reset between edges
        start_to_run(4'b0110);
        cyc(3);
        expect_out("run_pre_reset", 4'b0110, 3'd3, 1'b0, 2'b00);
        #1 rst = 1'b1;
        #1;
        expect_out("async_reset", 4'b0000, 3'd0, 1'b0, 2'b00);
        en = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Held input: watchdog fault if enabled, otherwise RUN persists
        start_to_run(4'b1001);
        cyc(5100);
`ifdef HB_WATCHDOG_EN
        expect_out("wdt_hold", 4'b0000, 3'd4, 1'b1, 2'b10);
`else
        expect_out("no_wdt_hold", 4'b1001, 3'd3, 1'b0, 2'b00);
`endif
        en = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        expect_out("exit_hold", 4'b0000, 3'd0, 1'b0, 2'b00);

        // Toggling input keeps RUN alive
        start_to_run(4'b1001);
        cyc(4000);
        iq = 4'b0110;
        cyc(4000);
        iq = 4'b1001;
        cyc(4000);
        expect_out("toggle_alive", 4'b1001, 3'd3, 1'b0, 2'b00);
        en = 1'b0;
        cyc(2);
        expect_out("final_idle", 4'b0000, 3'd0, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hbridge_startup_sequencer.md
Name: hbridge_startup_sequencer

Overview:
Registered output stage between the dead-time block's {Q4,Q3,Q2,Q1} outputs and the H-bridge gate pins Q[3:0]. It sequences converter start-up in three steps: bootstrap pre-charge (low sides on), then forced sigma=+1, then normal pass-through of the dead-timed gate pattern. It detects leg shoot-through and latches a fault. The whole block runs on clk_100M.

Parameters:
CLK_DIV, 100, clock cycles per 1 us tick (100 MHz clock)
T_PRECHARGE, 11, pre-charge duration in ticks
T_FORCE, 6, forced sigma=+1 duration in ticks
T_WDT, 50, watchdog timeout in ticks (used only with HB_WATCHDOG_EN)

Ports:
i_clock  in  1  system clock, clk_100M
i_RESET  in  1  asynchronous reset, active-high
i_enable  in  1  converter enable (debounced sw[0]); synchronous level
i_fault_clear  in  1  fault acknowledge; level
i_Q  in  4  dead-timed gate pattern, bit0=M1 leg1 high, bit1=M2 leg2 high, bit2=M3 leg1 low, bit3=M4 leg2 low
o_Q  out  4  registered gate drive to the bridge
o_state  out  3  current state encoding
o_on  out  1  high when state is FORCE or RUN
o_vg  out  1  high when state is RUN
o_fault  out  1  fault latched
o_fault_code  out  2  01 = shoot-through, 10 = watchdog, 00 = none

Behaviour:
- Reset (async): state IDLE, o_Q=0000, o_on=0, o_vg=0, o_fault=0, o_fault_code=00, all counters 0.
- States: IDLE=0, PRECHARGE=1, FORCE=2, RUN=3, FAULT=4.
- Counter: one phase counter of width $clog2(max(T_PRECHARGE,T_FORCE,T_WDT)*CLK_DIV). It clears on every state change and increments each cycle otherwise.
- IDLE: o_Q=0000. On i_enable=1, go to PRECHARGE.
- PRECHARGE: o_Q=1100 (both low sides on). After exactly T_PRECHARGE*CLK_DIV cycles in this state, go to FORCE.
- FORCE: o_Q=1001 (M1+M4, sigma=+1). After exactly T_FORCE*CLK_DIV cycles, go to RUN.
- RUN: o_Q <= i_Q, so o_Q shows i_Q one clock later. Shoot-through is (i_Q[0]&i_Q[2]) | (i_Q[1]&i_Q[3]).
  - On shoot-through: o_Q loads 0000 in the same update (the illegal pattern never reaches the pins), state goes to FAULT, o_fault_code=01.
- i_enable=0 in PRECHARGE, FORCE or RUN: the next cycle goes to IDLE with o_Q=0000 and no fault. A later re-enable restarts from PRECHARGE.
- FAULT: o_Q=0000 and o_fault=1, held regardless of i_enable. Exit to IDLE only when i_fault_clear=1 and i_enable=0 in the same cycle; o_fault and o_fault_code then clear.
  - i_fault_clear with i_enable=1 is ignored.
- Priority when events coincide:
  - shoot-through beats i_enable falling (goes to FAULT);
  - i_enable falling beats phase timeout (goes to IDLE).
- Status outputs: o_state, o_on and o_vg are registered and consistent with the state, so they are valid on the same cycle the new o_Q pattern appears.
- Final safety gate: o_Q is additionally ANDed with a registered copy of i_enable. The pins drop to 0000 in the first cycle after enable goes low, in every state.

Optional Feature:
HB_WATCHDOG_EN
- Defined: in RUN, the phase counter restarts on every change of i_Q. If i_Q stays unchanged for T_WDT*CLK_DIV cycles, the block goes to FAULT with o_fault_code=10 and o_Q=0000. This catches a stalled hybrid controller.
- Undefined: no watchdog. RUN lasts indefinitely and o_fault_code never takes the value 10.

Test Plan:
1. Start-up timing: reset, then i_enable=1 at cycle 0. Required: o_Q=1100 for exactly 1100 cycles, then 1001 for exactly 600 cycles, then o_vg=1 and o_Q follows i_Q with 1-cycle latency.
2. Shoot-through: in RUN, drive i_Q=0101. Required: o_Q never shows 0101, o_Q=0000 next cycle, o_fault=1, o_fault_code=01.
3. Fault clear: in FAULT, pulse i_fault_clear with i_enable=1, then with i_enable=0. Required: no effect for the first pulse; the second gives IDLE with o_fault=0 and o_fault_code=00.
4. Enable drop: drop i_enable at cycle 500 of PRECHARGE. Required: o_Q=0000 next cycle, IDLE, no fault. Re-enable gives a full 1100-cycle pre-charge.
5. Async reset: assert i_RESET mid-RUN, between clock edges. Required: o_Q=0000 and state IDLE immediately, without waiting for a clock edge.
6. Watchdog, built with HB_WATCHDOG_EN: hold i_Q=1001 in RUN for 5000 cycles. Required: FAULT with o_fault_code=10. Toggling i_Q every 4000 cycles produces no fault.
